// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port integer register file.
package rf_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;

    function automatic int rf_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int DEF_AW = rf_aw(DEF_NREG);

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic [DEF_XLEN-1:0] data;
        logic                busy;
    } rd_resp_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side of the register file: read ports, writeback, issue-time busy marking, flush.
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = DEF_NRD
);
    localparam int AW = rf_aw(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                set_busy;
    logic [AW-1:0]       set_addr;
    logic                flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, set_busy, set_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, set_busy, set_addr, flush,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register detect, writeback bypass, stored data/busy mux.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREG)
) (
    input  logic [AW-1:0]              addr,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_busy
);

    always_comb begin
        rd_data = regs[addr];
        rd_busy = busy[addr];
        if (ZERO_REG != 0 && addr == '0) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (BYPASS != 0 && wr_en && wr_addr == addr) begin
            // the value being written retires the producer, so it is never busy
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Flop-based integer register file with NRD read ports, write bypass and per-register busy scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int NRD      = DEF_NRD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int AW = rf_aw(NREG);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           busy_nxt;
    logic                      wr_ok;
    logic                      set_ok;

    assign wr_ok  = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
    assign set_ok = bus.set_busy && !(ZERO_REG != 0 && bus.set_addr == '0);

    // set is applied after the clear so a new producer wins over a retiring one
    always_comb begin
        busy_nxt = busy;
        if (bus.flush) begin
            busy_nxt = '0;
        end else begin
            if (bus.wr_en) busy_nxt[bus.wr_addr] = 1'b0;
            if (set_ok)    busy_nxt[bus.set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        rf_read_port #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .addr    (bus.rd_addr[i*AW +: AW]),
            .regs    (regs),
            .busy    (busy),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_data (bus.rd_data[i*XLEN +: XLEN]),
            .rd_busy (bus.rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-port bypassing instance and a 2-port non-bypassing instance.
module tb_regfile_mp;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(4)) if_a ();
    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) if_b ();

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        sb;
        logic [4:0]  sa;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
    } vec_t;
    vec_t vt[18];

    task automatic push_exp(input string name, input int port, input logic [31:0] d, input logic b);
        exp_t e;
        e.name = name;
        e.port = port;
        e.data = d;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic drain(input logic [127:0] dat, input logic [3:0] bsy);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dat[e.port*32 +: 32] !== e.data || bsy[e.port] !== e.busy) begin
                errors++;
                $display("FAIL %s port%0d: got data=%08h busy=%b, want data=%08h busy=%b",
                         e.name, e.port, dat[e.port*32 +: 32], bsy[e.port], e.data, e.busy);
            end
        end
    endtask

    task automatic apply_a(input int idx, input vec_t v);
        @(negedge clk);
        rst_n         = !v.rst;
        if_a.wr_en    = v.we;
        if_a.wr_addr  = v.wa;
        if_a.wr_data  = v.wd;
        if_a.set_busy = v.sb;
        if_a.set_addr = v.sa;
        if_a.flush    = v.fl;
        if_a.rd_addr  = {v.r1, v.r0, v.r1, v.r0};
        #1;
        push_exp($sformatf("vec%0d", idx), 0, v.d0, v.b0);
        push_exp($sformatf("vec%0d", idx), 1, v.d1, v.b1);
        push_exp($sformatf("vec%0d_alias", idx), 2, v.d0, v.b0);
        push_exp($sformatf("vec%0d_alias", idx), 3, v.d1, v.b1);
        drain(if_a.rd_data, if_a.rd_busy);
    endtask

    task automatic apply_b(input string name, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic sbz, input logic [4:0] sa, input logic [4:0] r0, input logic [4:0] r1,
                           input logic [31:0] d0, input logic b0, input logic [31:0] d1, input logic b1);
        @(negedge clk);
        if_b.wr_en    = we;
        if_b.wr_addr  = wa;
        if_b.wr_data  = wd;
        if_b.set_busy = sbz;
        if_b.set_addr = sa;
        if_b.flush    = 1'b0;
        if_b.rd_addr  = {r1, r0};
        #1;
        push_exp(name, 0, d0, b0);
        push_exp(name, 1, d1, b1);
        drain({64'h0, if_b.rd_data}, {2'b00, if_b.rd_busy});
    endtask

    initial begin
        rst_n = 1'b0;
        if_a.rd_addr = '0; if_a.wr_en = 1'b0; if_a.wr_addr = '0; if_a.wr_data = '0;
        if_a.set_busy = 1'b0; if_a.set_addr = '0; if_a.flush = 1'b0;
        if_b.rd_addr = '0; if_b.wr_en = 1'b0; if_b.wr_addr = '0; if_b.wr_data = '0;
        if_b.set_busy = 1'b0; if_b.set_addr = '0; if_b.flush = 1'b0;

        //          rst   we    wa     wd            sb    sa    fl    r0     r1     d0            b0    d1            b1
        vt[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5,  5'd6,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vt[2]  = '{1'b0, 1'b1, 5'd0,  32'h1234,     1'b1, 5'd0, 1'b0, 5'd0,  5'd5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b0, 5'd7,  5'd5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd12, 32'h0,        1'b1, 32'h0,        1'b0};
        vt[6]  = '{1'b0, 1'b1, 5'd7,  32'hA5,       1'b0, 5'd0, 1'b0, 5'd7,  5'd7,  32'hA5,       1'b0, 32'hA5,       1'b0};
        vt[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd5,  32'hA5,       1'b0, 32'hDEADBEEF, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 5'd7,  32'h77,       1'b1, 5'd7, 1'b0, 5'd7,  5'd3,  32'h77,       1'b0, 32'h0,        1'b0};
        vt[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 1'b0, 5'd7,  5'd3,  32'h77,       1'b1, 32'h0,        1'b0};
        vt[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 1'b0, 5'd3,  5'd9,  32'h0,        1'b1, 32'h0,        1'b0};
        vt[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 1'b1, 5'd9,  5'd4,  32'h0,        1'b1, 32'h0,        1'b0};
        vt[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd3,  5'd9,  32'h0,        1'b0, 32'h0,        1'b0};
        vt[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd4,  5'd7,  32'h0,        1'b0, 32'h77,       1'b0};
        vt[14] = '{1'b0, 1'b1, 5'd12, 32'h55AA55AA, 1'b0, 5'd0, 1'b0, 5'd12, 5'd12, 32'h55AA55AA, 1'b0, 32'h55AA55AA, 1'b0};
        vt[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd12, 5'd12, 32'h55AA55AA, 1'b0, 32'h55AA55AA, 1'b0};
        vt[16] = '{1'b1, 1'b1, 5'd12, 32'h99,       1'b1, 5'd12, 1'b0, 5'd12, 5'd5, 32'h99,       1'b0, 32'hDEADBEEF, 1'b0};
        vt[17] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd12, 5'd5,  32'h0,        1'b0, 32'h0,        1'b0};

        // one reset edge, then sweep every address across all four ports
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            if_a.rd_addr = {5'((a + 3) % 32), 5'((a + 2) % 32), 5'((a + 1) % 32), 5'(a)};
            #1;
            for (int p = 0; p < 4; p++) push_exp($sformatf("reset_sweep_a%0d", a), p, 32'h0, 1'b0);
            drain(if_a.rd_data, if_a.rd_busy);
        end

        for (int i = 0; i < 18; i++) apply_a(i, vt[i]);

        @(negedge clk);
        rst_n = 1'b1;
        if_a.wr_en = 1'b0; if_a.set_busy = 1'b0; if_a.flush = 1'b0;

        // non-bypassing instance: writes and busy clears appear only after the edge
        apply_b("nobyp_wr",    1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'h0, 1'b0, 32'h0, 1'b0);
        apply_b("nobyp_after", 1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 5'd5, 5'd6, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        apply_b("nobyp_busy",  1'b1, 5'd6, 32'h11,       1'b0, 5'd0, 5'd6, 5'd5, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        apply_b("nobyp_clr",   1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd6, 5'd0, 32'h11, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
